// File: rtl/interact_pkg.sv
// rtl/interact_pkg.sv - APF bridge address constants and register index map
package interact_pkg;

    localparam logic [31:0] APF_REG_BASE    = 32'hF100_0000;
    localparam logic [31:0] APF_CMD_ADDR    = 32'hF000_0000;
    localparam int unsigned APF_STRIDE_LOG2 = 24;

    localparam int unsigned REG_DIP = 0;
    localparam int unsigned REG_MOD = 1;
    localparam int unsigned REG_FLT = 2;
    localparam int unsigned REG_EXT = 3;
    localparam int unsigned REG_NVR = 4;
    localparam int unsigned REG_VOL = 5;
    localparam int unsigned REG_PAL = 6;
    localparam int unsigned REG_SND = 7;
    localparam int unsigned REG_CHT = 8;
    localparam int unsigned REG_SAV = 9;
    localparam int unsigned REG_STH = 10;
    localparam int unsigned NUM_REGS_DEF = 11;

    // DIP switches and the expansion selector both need the core restarted
    localparam logic [63:0] DEF_RST_MASK = 64'h009;

    function automatic logic [31:0] reg_addr(input logic [31:0] base,
                                             input int unsigned stride_log2,
                                             input int unsigned idx);
        return base + (32'(idx) << stride_log2);
    endfunction

endpackage

// File: rtl/interact_reset_timer.sv
// rtl/interact_reset_timer.sv - retriggerable core reset hold timer
module interact_reset_timer #(
    parameter int unsigned RST_CYCLES = 8000
) (
    input  logic clk_74a,
    input  logic reset_n,
    input  logic trig,
    output logic reset_sw
);

    localparam int unsigned      CW       = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(RST_CYCLES);
    localparam logic [0:0]       ST_IDLE  = 1'b0;
    localparam logic [0:0]       ST_HOLD  = 1'b1;

    logic [0:0]    r_state;
    logic [CW-1:0] r_count;

    if (RST_CYCLES < 1) begin : g_bad_cycles
        $error("interact_reset_timer: RST_CYCLES must be >= 1");
    end

    // count holds the number of HOLD cycles still to go, including the current one
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_HOLD;
            r_count <= CNT_LOAD;
        end else if (trig) begin
            r_state <= ST_HOLD;
            r_count <= CNT_LOAD;
        end else if (r_state == ST_HOLD) begin
            if (r_count == CW'(1)) begin
                r_state <= ST_IDLE;
            end else begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign reset_sw = (r_state == ST_HOLD);

endmodule

// File: rtl/interact_regbank.sv
// rtl/interact_regbank.sv - APF bridge register bank with strobes and core reset trigger
module interact_regbank
    import interact_pkg::*;
#(
    parameter int unsigned                NUM_REGS    = NUM_REGS_DEF,
    parameter logic [31:0]                REG_BASE    = APF_REG_BASE,
    parameter int unsigned                STRIDE_LOG2 = APF_STRIDE_LOG2,
    parameter logic [31:0]                CMD_ADDR    = APF_CMD_ADDR,
    parameter logic [NUM_REGS-1:0]        RST_MASK    = NUM_REGS'(DEF_RST_MASK),
    parameter int unsigned                RST_CYCLES  = 8000,
    parameter logic [NUM_REGS*32-1:0]     RESET_VALS  = '0
) (
    input  logic                     clk_74a,
    input  logic                     reset_n,
    input  logic [31:0]              bridge_addr,
    input  logic                     bridge_wr,
    input  logic [31:0]              bridge_wr_data,
    input  logic                     bridge_rd,
    output logic [31:0]              bridge_rd_data,
    input  logic                     ext_rst_req,
    output logic [NUM_REGS*32-1:0]   regs,
    output logic [NUM_REGS-1:0]      reg_wr_stb,
    output logic [NUM_REGS-1:0]      reg_changed,
    output logic                     reset_sw
);

    logic [NUM_REGS*32-1:0] r_regs;
    logic [NUM_REGS-1:0]    r_wr_stb;
    logic [NUM_REGS-1:0]    r_changed;
    logic [31:0]            r_rd_data;

    logic [NUM_REGS-1:0]    w_hit;
    logic [NUM_REGS-1:0]    w_wr_hit;
    logic                   w_cmd_hit;
    logic                   w_trig;
    logic                   w_reset_sw;
    logic [31:0]            w_rd_val;

    if (NUM_REGS < 1 || NUM_REGS > 64) begin : g_bad_num_regs
        $error("interact_regbank: NUM_REGS must be 1..64");
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_dec
        localparam logic [31:0] ADDR = reg_addr(REG_BASE, STRIDE_LOG2, g);
        if (ADDR == CMD_ADDR) begin : g_cmd_clash
            $error("interact_regbank: CMD_ADDR collides with a register address");
        end
        assign w_hit[g] = (bridge_addr == ADDR);
    end

    assign w_cmd_hit = (bridge_addr == CMD_ADDR);
    assign w_wr_hit  = w_hit & {NUM_REGS{bridge_wr}};
    assign w_trig    = (bridge_wr && w_cmd_hit) || (|(w_wr_hit & RST_MASK)) || ext_rst_req;

    // unmapped reads fall through to the current value so the data bus holds
    always_comb begin
        w_rd_val = r_rd_data;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (w_hit[i]) w_rd_val = r_regs[32*i +: 32];
        end
        if (w_cmd_hit) w_rd_val = {31'b0, ~w_reset_sw};
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            r_regs    <= RESET_VALS;
            r_wr_stb  <= '0;
            r_changed <= '0;
            r_rd_data <= '0;
        end else begin
            if (bridge_rd) r_rd_data <= w_rd_val;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                r_wr_stb[i]  <= w_wr_hit[i];
                r_changed[i] <= w_wr_hit[i] && (bridge_wr_data != r_regs[32*i +: 32]);
                if (w_wr_hit[i]) r_regs[32*i +: 32] <= bridge_wr_data;
            end
        end
    end

    interact_reset_timer #(
        .RST_CYCLES (RST_CYCLES)
    ) u_reset_timer (
        .clk_74a  (clk_74a),
        .reset_n  (reset_n),
        .trig     (w_trig),
        .reset_sw (w_reset_sw)
    );

    assign regs           = r_regs;
    assign reg_wr_stb     = r_wr_stb;
    assign reg_changed    = r_changed;
    assign bridge_rd_data = r_rd_data;
    assign reset_sw       = w_reset_sw;

endmodule

// File: tb/tb_interact_regbank.sv
// tb/tb_interact_regbank.sv - self-checking bench for interact_regbank against a cycle-indexed model
module tb_interact_regbank;

    localparam int              NR   = 11;
    localparam int              W    = NR * 32;
    localparam int              RC   = 8000;
    localparam logic [W-1:0]    RV   = (352'hA5 << 96);
    localparam logic [31:0]     BASE = 32'hF100_0000;
    localparam logic [31:0]     CMD  = 32'hF000_0000;
    localparam logic [NR-1:0]   MASK = 11'h009;

    logic           clk_74a = 1'b0;
    logic           reset_n;
    logic [31:0]    bridge_addr;
    logic           bridge_wr;
    logic [31:0]    bridge_wr_data;
    logic           bridge_rd;
    logic [31:0]    bridge_rd_data;
    logic           ext_rst_req;
    logic [W-1:0]   regs;
    logic [NR-1:0]  reg_wr_stb;
    logic [NR-1:0]  reg_changed;
    logic           reset_sw;

    always #5 clk_74a = ~clk_74a;

    interact_regbank #(
        .RESET_VALS (RV)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .bridge_addr    (bridge_addr),
        .bridge_wr      (bridge_wr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd      (bridge_rd),
        .bridge_rd_data (bridge_rd_data),
        .ext_rst_req    (ext_rst_req),
        .regs           (regs),
        .reg_wr_stb     (reg_wr_stb),
        .reg_changed    (reg_changed),
        .reset_sw       (reset_sw)
    );

    // model: register contents plus the cycle index of the most recent reset trigger
    logic [31:0]    m_regs [NR];
    logic [31:0]    m_rd;
    logic [NR-1:0]  m_stb;
    logic [NR-1:0]  m_chg;
    int             cyc;
    int             m_last;
    int             n_pass = 0;
    int             n_fail = 0;
    int             n_total = 0;

    function automatic int reg_index(input logic [31:0] a);
        logic [31:0] off;
        if (a < BASE) return -1;
        off = a - BASE;
        if (off[23:0] != 24'd0) return -1;
        if (int'(off[31:24]) >= NR) return -1;
        return int'(off[31:24]);
    endfunction

    function automatic logic model_sw();
        return (cyc > m_last) && (cyc <= m_last + RC);
    endfunction

    function automatic logic [W-1:0] model_flat();
        logic [W-1:0] f;
        for (int i = 0; i < NR; i++) f[32*i +: 32] = m_regs[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("regs", regs, model_flat());
        chk("rd_data", W'(bridge_rd_data), W'(m_rd));
        chk("wr_stb", W'(reg_wr_stb), W'(m_stb));
        chk("changed", W'(reg_changed), W'(m_chg));
        chk("reset_sw", W'(reset_sw), W'(model_sw()));
    endtask

    task automatic step();
        int   idx;
        logic trig;
        idx  = reg_index(bridge_addr);
        trig = ext_rst_req;
        if (bridge_rd) begin
            if (bridge_addr == CMD) m_rd = {31'b0, ~model_sw()};
            else if (idx >= 0) m_rd = m_regs[idx];
        end
        m_stb = '0;
        m_chg = '0;
        if (bridge_wr) begin
            if (bridge_addr == CMD) begin
                trig = 1'b1;
            end else if (idx >= 0) begin
                m_stb[idx] = 1'b1;
                m_chg[idx] = (m_regs[idx] != bridge_wr_data);
                m_regs[idx] = bridge_wr_data;
                if (MASK[idx]) trig = 1'b1;
            end
        end
        if (trig) m_last = cyc;
        @(posedge clk_74a);
        #1;
        cyc++;
        bridge_wr = 1'b0;
        bridge_rd = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        step();
    endtask

    task automatic rd(input logic [31:0] a);
        bridge_addr = a; bridge_rd = 1'b1;
        step();
    endtask

    task automatic do_reset();
        logic [W-1:0] rv;
        rv = RV;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) m_regs[i] = rv[32*i +: 32];
        m_rd = '0; m_stb = '0; m_chg = '0;
        chk("rst_regs", regs, rv);
        chk("rst_rd", W'(bridge_rd_data), W'(0));
        chk("rst_stb", W'(reg_wr_stb | reg_changed), W'(0));
        chk("rst_sw", W'(reset_sw), W'(1));
        repeat (2) @(posedge clk_74a);
        bridge_wr = 1'b0; bridge_rd = 1'b0; ext_rst_req = 1'b0;
        #1;
        reset_n = 1'b1;
        cyc = 0;
        m_last = -1;
        check_all();
    endtask

    initial begin
        int n0, fall, hi, lst;
        reset_n = 1'b1;
        bridge_addr = '0; bridge_wr = 1'b0; bridge_wr_data = '0;
        bridge_rd = 1'b0; ext_rst_req = 1'b0;
        cyc = 0; m_last = -1;
        #3;

        // 1: power-on values and reset hold length
        do_reset();
        chk("t1_reg3", W'(regs[127:96]), W'(32'hA5));
        hi = reset_sw ? 1 : 0;
        for (int k = 0; k < RC + 5; k++) begin
            step();
            if (reset_sw) hi++;
        end
        chk("t1_hold_len", W'(hi), W'(RC));

        // 2: plain write, then rewrite of identical value
        wr(32'hF200_0000, 32'h1234_5678);
        chk("t2_reg1", W'(regs[63:32]), W'(32'h1234_5678));
        chk("t2_stb1", W'(reg_wr_stb[1] & reg_changed[1]), W'(1));
        chk("t2_sw", W'(reset_sw), W'(0));
        step();
        chk("t2_stb_gone", W'(reg_wr_stb), W'(0));
        wr(32'hF200_0000, 32'h1234_5678);
        chk("t2_same_stb", W'(reg_wr_stb[1]), W'(1));
        chk("t2_same_chg", W'(reg_changed[1]), W'(0));

        // 3: masked register write and retrigger
        n0 = cyc;
        wr(32'hF400_0000, 32'h0000_3333);
        chk("t3_sw_on", W'(reset_sw), W'(1));
        while (cyc < n0 + 5000) step();
        wr(32'hF400_0000, 32'h0000_4444);
        for (int k = 0; k < 20000 && reset_sw; k++) step();
        fall = cyc;
        chk("t3_fall", W'(fall), W'(n0 + 5000 + RC + 1));

        // 4: read-old on same-cycle write, command status
        wr(32'hF300_0000, 32'h0000_2222);
        bridge_rd = 1'b1;
        wr(32'hF300_0000, 32'h0000_BEEF);
        chk("t4_rd_old", W'(bridge_rd_data), W'(32'h2222));
        rd(32'hF300_0000);
        chk("t4_rd_new", W'(bridge_rd_data), W'(32'hBEEF));
        wr(CMD, 32'h0);
        rd(CMD);
        chk("t4_cmd_hold", W'(bridge_rd_data), W'(0));
        for (int k = 0; k < 20000 && reset_sw; k++) step();
        rd(CMD);
        chk("t4_cmd_idle", W'(bridge_rd_data), W'(1));

        // 5: unmapped accesses
        rd(32'hF300_0000);
        wr(32'hF100_0004, 32'hDEAD_0001);
        chk("t5_stb_low", W'(reg_wr_stb), W'(0));
        wr(32'hFC00_0000, 32'hDEAD_0002);
        chk("t5_stb_far", W'(reg_wr_stb), W'(0));
        rd(32'hF100_0004);
        chk("t5_rd_hold", W'(bridge_rd_data), W'(32'hBEEF));
        rd(32'hFC00_0000);
        chk("t5_rd_hold2", W'(bridge_rd_data), W'(32'hBEEF));

        // random traffic over mapped, command and unmapped addresses
        for (int k = 0; k < 400; k++) begin
            int sel, idx;
            sel = $urandom_range(0, 9);
            idx = $urandom_range(0, NR - 1);
            case (sel)
                6:       bridge_addr = CMD;
                7:       bridge_addr = BASE + (32'(idx) << 24) + 32'($urandom_range(1, 255));
                8:       bridge_addr = BASE + (32'($urandom_range(NR, 15)) << 24);
                9:       bridge_addr = $urandom;
                default: bridge_addr = BASE + (32'(idx) << 24);
            endcase
            bridge_wr      = ($urandom % 2) == 0;
            bridge_rd      = ($urandom % 2) == 0;
            bridge_wr_data = ($urandom % 3 == 0) ? m_regs[idx] : 32'($urandom);
            ext_rst_req    = ($urandom % 32) == 0;
            step();
        end
        ext_rst_req = 1'b0;

        // 6: reset mid-hold with dirty registers and a write in flight, then long ext request
        wr(32'hF200_0000, 32'hCAFE_0001);
        wr(32'hF600_0000, 32'hCAFE_0005);
        wr(CMD, 32'h0);
        for (int k = 0; k < 100; k++) step();
        bridge_addr = 32'hF500_0000; bridge_wr_data = 32'h5555_5555; bridge_wr = 1'b1;
        do_reset();
        chk("t6_reg1_clr", W'(regs[63:32]), W'(0));
        hi = reset_sw ? 1 : 0;
        for (int k = 0; k < RC + 5; k++) begin
            step();
            if (reset_sw) hi++;
        end
        chk("t6_reload", W'(hi), W'(RC));
        ext_rst_req = 1'b1;
        hi = 0;
        for (int k = 0; k < 20000; k++) begin
            step();
            if (reset_sw) hi++;
        end
        chk("t6_ext_hold", W'(hi), W'(20000));
        ext_rst_req = 1'b0;
        lst = cyc - 1;
        for (int k = 0; k < 20000 && reset_sw; k++) step();
        chk("t6_ext_fall", W'(cyc), W'(lst + RC + 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
